// File: rtl/uart_pkg.sv
// Shared definitions for the UART FIFO controller: command opcodes, FSM state
// encodings and STATUS response bit positions.
package uart_pkg;

  localparam logic [2:0] OP_STATUS = 3'b001;
  localparam logic [2:0] OP_READ   = 3'b010;
  localparam logic [2:0] OP_WRITE  = 3'b011;
  localparam logic [2:0] OP_CLEAR  = 3'b100;
  localparam logic [2:0] OP_RXCNT  = 3'b101;
  localparam logic [2:0] OP_TXCNT  = 3'b110;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  localparam int unsigned ST_RX_NONEMPTY = 0;
  localparam int unsigned ST_TX_FULL     = 1;
  localparam int unsigned ST_RX_OVERRUN  = 2;
  localparam int unsigned ST_TX_OVERRUN  = 3;
  localparam int unsigned ST_PARITY_ERR  = 4;
  localparam int unsigned ST_FRAME_ERR   = 5;
  localparam int unsigned ST_TX_BUSY     = 6;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             init_flag,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage is left unreset; only entries below count are ever observed.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_fifo_controller.sv
// UART controller with RX/TX FIFOs, configurable frame format and a
// registered command/response port on the instruction bus.
module uart_fifo_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned RX_DEPTH     = 16,
  parameter int unsigned TX_DEPTH     = 16
) (
  input  logic       clock,
  input  logic       init_flag,
  input  logic       UART_ENB,
  input  logic [2:0] instruction,
  input  logic [7:0] write_value,
  input  logic       rx,
  output logic       tx,
  output logic       wb_flag,
  output logic [7:0] wb_data
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned RXC_W = $clog2(RX_DEPTH) + 1;
  localparam int unsigned TXC_W = $clog2(TX_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_INV = (PARITY_ODD != 0);

  logic op_read_c, op_write_c, op_clear_c;
  logic rx_meta, rx_sync;

  rx_state_t            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_disc_q, rx_disc_d;
  logic                 rx_push_c, rx_perr_c, rx_ferr_c;

  tx_state_t            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_d, tx_pop_c, tx_busy_c;

  logic frame_err_q, parity_err_q, tx_ovr_q, rx_ovr_q;
  logic wb_flag_d;
  logic [7:0] wb_data_d;

  logic [DATA_BITS-1:0] rx_dout, tx_dout;
  logic [RXC_W-1:0]     rx_count;
  logic [TXC_W-1:0]     tx_count;
  logic rx_full, rx_empty, tx_full, tx_empty;

  assign op_read_c  = UART_ENB && (instruction == OP_READ);
  assign op_write_c = UART_ENB && (instruction == OP_WRITE);
  assign op_clear_c = UART_ENB && (instruction == OP_CLEAR);
  assign tx_busy_c  = (tx_state_q != TX_IDLE);

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock(clock), .init_flag(init_flag), .push(rx_push_c), .pop(op_read_c),
    .din(rx_shift_q), .dout(rx_dout), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock(clock), .init_flag(init_flag), .push(op_write_c), .pop(tx_pop_c),
    .din(write_value[DATA_BITS-1:0]), .dout(tx_dout), .count(tx_count),
    .full(tx_full), .empty(tx_empty)
  );

  // RX deserialiser: mid-bit sampling referenced from the start-bit edge.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_disc_d  = rx_disc_q;
    rx_push_c  = 1'b0;
    rx_perr_c  = 1'b0;
    rx_ferr_c  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync) begin
          rx_state_d = RX_START;
          rx_disc_d  = 1'b0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_MID) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == BIT_LAST) rx_state_d = PAR_EN ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_STOP;
          if (rx_sync != ((^rx_shift_q) ^ PAR_INV)) begin
            rx_perr_c = 1'b1;
            rx_disc_d = 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync) begin
            rx_push_c  = !rx_disc_q;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_c  = 1'b1;
            rx_disc_d  = 1'b1;
            rx_state_d = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_sync) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // TX serialiser; tx is registered from the current state, one cycle behind it.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop_c   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop_c   = 1'b1;
          tx_shift_d = tx_dout;
          tx_par_d   = (^tx_dout) ^ PAR_INV;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 1'b1;
          if (tx_bit_q == BIT_LAST) tx_state_d = PAR_EN ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state_q)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shift_q[0];
      TX_PARITY: tx_d = tx_par_q;
      default:   tx_d = 1'b1;
    endcase
  end

  // Command response, registered one cycle after the command edge.
  always_comb begin
    wb_flag_d = 1'b0;
    wb_data_d = '0;
    if (UART_ENB) begin
      case (instruction)
        OP_STATUS: begin
          wb_flag_d                 = 1'b1;
          wb_data_d[ST_RX_NONEMPTY] = !rx_empty;
          wb_data_d[ST_TX_FULL]     = tx_full;
          wb_data_d[ST_RX_OVERRUN]  = rx_ovr_q;
          wb_data_d[ST_TX_OVERRUN]  = tx_ovr_q;
          wb_data_d[ST_PARITY_ERR]  = parity_err_q;
          wb_data_d[ST_FRAME_ERR]   = frame_err_q;
          wb_data_d[ST_TX_BUSY]     = tx_busy_c;
        end
        OP_READ: begin
          wb_flag_d = 1'b1;
          if (!rx_empty) wb_data_d = 8'(rx_dout);
        end
        OP_RXCNT: begin
          wb_flag_d = 1'b1;
          wb_data_d = 8'(rx_count);
        end
        OP_TXCNT: begin
          wb_flag_d = 1'b1;
          wb_data_d = 8'(tx_count);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_disc_q    <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_par_q     <= 1'b0;
      tx           <= 1'b1;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      tx_ovr_q     <= 1'b0;
      rx_ovr_q     <= 1'b0;
      wb_flag      <= 1'b0;
      wb_data      <= '0;
    end else begin
      rx_meta      <= rx;
      rx_sync      <= rx_meta;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_disc_q    <= rx_disc_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_par_q     <= tx_par_d;
      tx           <= tx_d;
      // Sticky errors: a set in the same cycle as CLEAR takes priority.
      frame_err_q  <= (frame_err_q  && !op_clear_c) || rx_ferr_c;
      parity_err_q <= (parity_err_q && !op_clear_c) || rx_perr_c;
      tx_ovr_q     <= (tx_ovr_q && !op_clear_c) || (op_write_c && tx_full && !tx_pop_c);
      rx_ovr_q     <= (rx_ovr_q && !op_clear_c) || (rx_push_c && rx_full && !op_read_c);
      wb_flag      <= wb_flag_d;
      wb_data      <= wb_data_d;
    end
  end

endmodule
